// File: rtl/trig_table_writer.sv
// trig_table_writer
// Runtime loader for the per-bin sine/cosine wave tables and the per-bin
// wave-length (wrap) table. A valid/ready word stream carries, for each bin,
// one header word (wave length L) followed by 2L interleaved sin/cos samples.
// Positions L..2**NS-1 of every bin are zero-filled so stale samples from a
// previous load can never be read back by the trig readers.
module trig_table_writer #(
  parameter int N    = 16,
  parameter int BINS = 24,
  parameter int NS   = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [N-1:0]                in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        tbl_we,
  output logic [$clog2(BINS)+NS-1:0]  tbl_addr,
  output logic [N-1:0]                tbl_sin,
  output logic [N-1:0]                tbl_cos,
  output logic                        len_we,
  output logic [$clog2(BINS)-1:0]     len_bin,
  output logic [NS-1:0]               len_value
);

  localparam int BW = $clog2(BINS);
  localparam logic [BW-1:0] LAST_BIN = BW'(BINS - 1);
  localparam logic [NS-1:0] LAST_POS = {NS{1'b1}};
  localparam logic [NS-1:0] MIN_LEN  = NS'(2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_SIN  = 3'd2,
    S_COS  = 3'd3,
    S_FILL = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  // A header is legal when its upper bits are clear and 2 <= L (L <= 2**NS-1 by width).
  function automatic logic hdr_legal(input logic [N-1:0] w);
    return (w[N-1:NS] == {(N-NS){1'b0}}) && (w[NS-1:0] >= MIN_LEN);
  endfunction

  state_t          state_r, state_s;
  logic [BW-1:0]   bin_r, bin_s;
  logic [NS-1:0]   pos_r, pos_s;
  logic [NS-1:0]   len_r, len_s;
  logic [N-1:0]    sin_lat_r, sin_lat_s;
  logic            word_s;
  logic            in_ready_s, busy_s, done_s, err_s;
  logic            tbl_we_s, len_we_s;
  logic [BW+NS-1:0] tbl_addr_s;
  logic [N-1:0]    tbl_sin_s, tbl_cos_s;
  logic [BW-1:0]   len_bin_s;
  logic [NS-1:0]   len_value_s;

  // Next-state, counter and write-strobe decode; outputs are registered below.
  always_comb begin
    state_s     = state_r;
    bin_s       = bin_r;
    pos_s       = pos_r;
    len_s       = len_r;
    sin_lat_s   = sin_lat_r;
    tbl_we_s    = 1'b0;
    tbl_addr_s  = {(BW+NS){1'b0}};
    tbl_sin_s   = {N{1'b0}};
    tbl_cos_s   = {N{1'b0}};
    len_we_s    = 1'b0;
    len_bin_s   = {BW{1'b0}};
    len_value_s = {NS{1'b0}};
    // in_ready is registered from the state decode, so the handshake never loops through in_valid
    word_s      = in_valid & in_ready;

    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_s = S_HDR;
          bin_s   = {BW{1'b0}};
          pos_s   = {NS{1'b0}};
        end else begin
          state_s = state_r;
        end
      end
      S_HDR: begin
        if (word_s) begin
          if (hdr_legal(in_data)) begin
            state_s     = S_SIN;
            pos_s       = {NS{1'b0}};
            len_s       = in_data[NS-1:0];
            len_we_s    = 1'b1;
            len_bin_s   = bin_r;
            len_value_s = in_data[NS-1:0];
          end else begin
            state_s = S_ERR;
          end
        end else begin
          state_s = state_r;
        end
      end
      S_SIN: begin
        if (word_s) begin
          sin_lat_s = in_data;
          state_s   = S_COS;
        end else begin
          state_s = state_r;
        end
      end
      S_COS: begin
        if (word_s) begin
          tbl_we_s   = 1'b1;
          tbl_addr_s = {bin_r, pos_r};
          tbl_sin_s  = sin_lat_r;
          tbl_cos_s  = in_data;
          // pos never exceeds L <= 2**NS-1 here, so the increment cannot wrap
          pos_s      = pos_r + NS'(1);
          state_s    = (pos_r == (len_r - NS'(1))) ? S_FILL : S_SIN;
        end else begin
          state_s = state_r;
        end
      end
      S_FILL: begin
        tbl_we_s   = 1'b1;
        tbl_addr_s = {bin_r, pos_r};
        if (pos_r == LAST_POS) begin
          if (bin_r == LAST_BIN) begin
            state_s = S_DONE;
          end else begin
            bin_s   = bin_r + BW'(1);
            state_s = S_HDR;
          end
        end else begin
          pos_s = pos_r + NS'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    in_ready_s = (state_s == S_HDR) || (state_s == S_SIN) || (state_s == S_COS);
    busy_s     = in_ready_s || (state_s == S_FILL);
    done_s     = (state_s == S_DONE);
    err_s      = (state_s == S_ERR);
  end

  // State, counters and every output register; rst aborts immediately to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      bin_r     <= {BW{1'b0}};
      pos_r     <= {NS{1'b0}};
      len_r     <= {NS{1'b0}};
      sin_lat_r <= {N{1'b0}};
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      tbl_we    <= 1'b0;
      tbl_addr  <= {(BW+NS){1'b0}};
      tbl_sin   <= {N{1'b0}};
      tbl_cos   <= {N{1'b0}};
      len_we    <= 1'b0;
      len_bin   <= {BW{1'b0}};
      len_value <= {NS{1'b0}};
    end else begin
      state_r   <= state_s;
      bin_r     <= bin_s;
      pos_r     <= pos_s;
      len_r     <= len_s;
      sin_lat_r <= sin_lat_s;
      in_ready  <= in_ready_s;
      busy      <= busy_s;
      done      <= done_s;
      err       <= err_s;
      tbl_we    <= tbl_we_s;
      tbl_addr  <= tbl_addr_s;
      tbl_sin   <= tbl_sin_s;
      tbl_cos   <= tbl_cos_s;
      len_we    <= len_we_s;
      len_bin   <= len_bin_s;
      len_value <= len_value_s;
    end
  end

endmodule

// File: tb/tb_trig_table_writer.sv
// tb_trig_table_writer
// Directed bench: drives whole and partial table loads, and compares every
// table and wrap-table write against the stream the bench itself generated.
module tb_trig_table_writer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic        tbl_we;
  logic [10:0] tbl_addr;
  logic [15:0] tbl_sin;
  logic [15:0] tbl_cos;
  logic        len_we;
  logic [4:0]  len_bin;
  logic [5:0]  len_value;

  int n_checks = 0;
  int n_fail   = 0;
  int timeouts = 0;
  int wr_idx   = 0;
  int wr_err   = 0;
  int len_idx  = 0;
  int len_err  = 0;
  int tot_tbl  = 0;
  int tot_len  = 0;
  int cyc      = 0;
  int lt[24];
  int tab_a[24];
  int tab_b[24];
  int mb, mp;
  logic [15:0] es, ec;

  trig_table_writer #(.N(16), .BINS(24), .NS(6)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .done(done), .err(err),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_sin(tbl_sin), .tbl_cos(tbl_cos),
    .len_we(len_we), .len_bin(len_bin), .len_value(len_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Write monitor: samples just after each edge and compares against the expected sequence.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (tbl_we === 1'b1) begin
      mb = wr_idx / 64;
      mp = wr_idx % 64;
      if (mb < 24) begin
        es = (mp < lt[mb]) ? 16'(mp)  : 16'd0;
        ec = (mp < lt[mb]) ? 16'(-mp) : 16'd0;
        if (tbl_addr !== 11'(wr_idx) || tbl_sin !== es || tbl_cos !== ec) wr_err = wr_err + 1;
      end else begin
        wr_err = wr_err + 1;
      end
      wr_idx  = wr_idx + 1;
      tot_tbl = tot_tbl + 1;
    end
    if (len_we === 1'b1) begin
      if (len_idx < 24) begin
        if (len_bin !== 5'(len_idx) || len_value !== 6'(lt[len_idx])) len_err = len_err + 1;
      end else begin
        len_err = len_err + 1;
      end
      len_idx = len_idx + 1;
      tot_len = tot_len + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reset_mon();
    wr_idx  = 0;
    wr_err  = 0;
    len_idx = 0;
    len_err = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one word; gap inserts an in_valid=0 cycle first.
  task automatic send(input logic [15:0] w, input bit gap);
    int t;
    if (timeouts != 0) return;
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_data  = w;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) timeouts++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_bins(input int b0, input int b1, input bit gaps, input bit poke);
    for (int b = b0; b < b1; b++) begin
      if (poke && b == 5) start = 1'b1;
      send(16'(lt[b]), gaps);
      start = 1'b0;
      for (int p = 0; p < lt[b]; p++) begin
        send(16'(p), gaps);
        send(16'(-p), gaps);
      end
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done !== 1'b1 && t < 6000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 6000) timeouts++;
  endtask

  task automatic check_full(input string t);
    check({t, "_len_cnt"},  32'(len_idx), 32'd24);
    check({t, "_len_err"},  32'(len_err), 32'd0);
    check({t, "_tbl_cnt"},  32'(wr_idx),  32'd1536);
    check({t, "_tbl_err"},  32'(wr_err),  32'd0);
    check({t, "_done"},     32'(done),    32'd1);
    check({t, "_busy"},     32'(busy),    32'd0);
    check({t, "_err"},      32'(err),     32'd0);
    check({t, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    int c0, exp_cyc, s_tbl, s_len;
    tab_a = '{55, 53, 52, 50, 49, 47, 46, 44, 43, 42, 40, 39,
              38, 37, 36, 35, 34, 33, 32, 31, 30, 30, 29, 29};
    tab_b = tab_a;
    tab_b[0] = 63;
    tab_b[1] = 2;
    lt = tab_a;

    // Reset held 3 cycles with in_valid asserted.
    rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 16'hFFFF;
    repeat (3) @(negedge clk);
    check("rst_tbl_we",   32'(tbl_we),    32'd0);
    check("rst_len_we",   32'(len_we),    32'd0);
    check("rst_in_ready", 32'(in_ready),  32'd0);
    check("rst_busy",     32'(busy),      32'd0);
    check("rst_done",     32'(done),      32'd0);
    check("rst_err",      32'(err),       32'd0);
    check("rst_addr",     32'(tbl_addr),  32'd0);
    check("rst_sin",      32'(tbl_sin),   32'd0);
    check("rst_len_val",  32'(len_value), 32'd0);
    check("rst_writes",   32'(tot_tbl + tot_len), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Full-rate load of table A, with cycle count.
    lt = tab_a;
    reset_mon();
    do_start();
    c0 = cyc;
    check("A_busy_start",  32'(busy),     32'd1);
    check("A_ready_start", 32'(in_ready), 32'd1);
    send_bins(0, 24, 1'b0, 1'b0);
    wait_done();
    exp_cyc = 0;
    for (int b = 0; b < 24; b++) exp_cyc += 65 + lt[b];
    check("A_cycles", 32'(cyc - c0), 32'(exp_cyc));
    check_full("A");

    // Backpressure load with boundary lengths 63 and 2, plus ignored start while busy.
    lt = tab_b;
    reset_mon();
    do_start();
    check("B_done_clr", 32'(done), 32'd0);
    check("B_ready_novalid", 32'(in_ready), 32'd1);
    send_bins(0, 24, 1'b1, 1'b1);
    wait_done();
    check_full("B");

    // Bad header L=1 at bin 3.
    lt = tab_a;
    reset_mon();
    do_start();
    send_bins(0, 3, 1'b0, 1'b0);
    send(16'd1, 1'b0);
    check("C_err",      32'(err),      32'd1);
    check("C_in_ready", 32'(in_ready), 32'd0);
    check("C_busy",     32'(busy),     32'd0);
    check("C_len_cnt",  32'(len_idx),  32'd3);
    check("C_tbl_cnt",  32'(wr_idx),   32'd192);
    check("C_tbl_err",  32'(wr_err),   32'd0);
    in_valid = 1'b1; in_data = 16'd5;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check("C_no_more_wr", 32'(wr_idx), 32'd192);
    reset_mon();
    do_start();
    check("C_err_clr", 32'(err),  32'd0);
    check("C_busy2",   32'(busy), 32'd1);
    send_bins(0, 24, 1'b0, 1'b0);
    wait_done();
    check_full("C");

    // Header with an upper bit set.
    reset_mon();
    do_start();
    send(16'h0120, 1'b0);
    check("D_err",     32'(err),     32'd1);
    check("D_len_cnt", 32'(len_idx), 32'd0);
    check("D_tbl_cnt", 32'(wr_idx),  32'd0);

    // Reset mid-load at bin 2, position 10 (sin already latched).
    reset_mon();
    do_start();
    check("E_err_clr", 32'(err), 32'd0);
    send_bins(0, 2, 1'b0, 1'b0);
    send(16'(lt[2]), 1'b0);
    for (int p = 0; p < 10; p++) begin
      send(16'(p), 1'b0);
      send(16'(-p), 1'b0);
    end
    send(16'd10, 1'b0);
    check("E_pre_cnt", 32'(wr_idx), 32'd138);
    rst = 1'b1; in_valid = 1'b1; in_data = 16'(-10);
    s_tbl = tot_tbl;
    s_len = tot_len;
    @(negedge clk);
    check("E_rst_we",   32'(tbl_we), 32'd0);
    check("E_rst_busy", 32'(busy),   32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    check("E_tbl_after", 32'(tot_tbl), 32'(s_tbl));
    check("E_len_after", 32'(tot_len), 32'(s_len));
    check("E_busy",      32'(busy),     32'd0);
    check("E_done",      32'(done),     32'd0);
    check("E_err",       32'(err),      32'd0);
    check("E_in_ready",  32'(in_ready), 32'd0);

    // Reload with a start pulse issued mid-load; must complete normally.
    lt = tab_a;
    reset_mon();
    do_start();
    send_bins(0, 24, 1'b0, 1'b1);
    wait_done();
    check_full("F");

    check("timeouts", 32'(timeouts), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trig_table_writer.md
# trig_table_writer

Runtime loader for the per-bin sine/cosine wave tables and the per-bin wave-length (wrap) table used by the DFT bin engine. It accepts a valid/ready word stream from the host or config interface and emits write strobes into the sin/cos sample RAMs, addressed by {bin, position}. For each bin it also writes the wave length into the phase-counter wrap table. This lets frequencies and sample rate be changed without regenerating ROM images. It sits between the configuration bus and the table RAMs; the trig readers and phase counters are unchanged.

## Interface
- N, 16, sample width in bits (signed two's complement)
- BINS, 24, number of bins (waves) per octave
- NS, 6, position address width; each wave occupies 2**NS table slots
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a full load; honoured only when busy=0
- in_data  in  N  stream word (header or sample)
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts in_data this cycle
- busy  out  1  load in progress
- done  out  1  full load completed; held until next accepted start or rst
- err  out  1  malformed header; held until next accepted start or rst
- tbl_we  out  1  sample write strobe
- tbl_addr  out  $clog2(BINS)+NS  {bin, position}
- tbl_sin  out  N  sine sample to write
- tbl_cos  out  N  cosine sample to write
- len_we  out  1  wrap-table write strobe
- len_bin  out  $clog2(BINS)  bin being written
- len_value  out  NS  wave length L for len_bin

## Operation
- Stream format for each bin, b = 0..BINS-1 in order:
  - one header word: bits [NS-1:0] = L, all higher bits 0;
  - then 2L sample words, interleaved sin0, cos0, sin1, cos1, …, sin(L-1), cos(L-1).
- Header is legal iff 2 <= L <= 2**NS-1 and upper bits are zero. Any other header goes to ERR.
- States:
  - IDLE: start moves to HDR; clears done and err; bin=0.
  - HDR: on handshake, legal header moves to SIN with pos=0 and len_we pulsed. Illegal header moves to ERR.
  - SIN: on handshake, latch sample and move to COS.
  - COS: on handshake, write {bin,pos} with the latched sin and this cos; pos++. If pos == L-1 (before increment), move to FILL; else move to SIN.
  - FILL: in_ready=0. Write sin=0, cos=0 to positions L..2**NS-1, one per cycle. After the last one: if bin == BINS-1, move to DONE; else bin++ and move to HDR.
  - DONE: done=1. start moves to HDR.
  - ERR: err=1; no writes. start moves to HDR.
- in_ready = 1 only in HDR, SIN and COS; it is a pure function of state, never of in_valid.
- busy = 1 in HDR, SIN, COS and FILL.
- start while busy is ignored.
- No writes are ever issued outside SIN→COS completion and FILL.

## Timing
- Reset value of every output is 0, and the state is IDLE. rst mid-load aborts immediately: no partial write is issued on or after the rst cycle, and done and err stay 0.
- All outputs are registered.
  - tbl_we/addr/sin/cos are valid in the cycle after the cos handshake, or after the FILL state cycle.
  - len_we/len_bin/len_value are valid in the cycle after the header handshake.
- Each strobe is a single-cycle pulse per write; back-to-back writes occur on consecutive cycles.
- Handshake is word = in_valid & in_ready. A stalled in_valid freezes the FSM with no side effects.
- Minimum cycles per bin at full rate: 1 + 2L + (2**NS - L).
- done rises the cycle after the final FILL write; busy falls the same cycle.
- Position counter is NS bits and never wraps past 2**NS-1. The bin counter never exceeds BINS-1.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 -> all outputs 0, in_ready=0; no writes.
- Full load, no stalls: L list 55,53,52,…,29,29; sin=pos, cos=-pos. Required:
  - exactly 24 len_we pulses carrying the correct (bin, L);
  - 24×64 tbl_we pulses, with addr {b,p}, sin=p/cos=-p for p<L and 0/0 for p>=L;
  - done=1, busy=0.
- Backpressure: same stream with in_valid toggled 1,0,1,0 -> identical write sequence; in_ready never depends on in_valid.
- Bad header: legal bins 0–2, then bin 3 header L=1 -> err=1 the next cycle, in_ready=0, no bin-3 writes. A subsequent start clears err; a clean reload then completes with done=1.
- Upper-bit header error: header 16'h0120 at bin 0 -> err=1, no len_we.
- Reset mid-load at bin 2, pos 10 -> no writes from the rst cycle onward, outputs 0. start ignored while busy in a reload; that reload completes normally.
